iiitb_pudc: RTL

IIITB_PUDC -- requirements
Module: iiitb_pudc

---
 rtl/iiitb_pudc.sv | 84 ++++++++
 1 files changed

// File: rtl/iiitb_pudc.sv
// Up/down counter with a runtime limit, wrap or saturate at the boundaries,
// a one-cycle Wrap pulse and a sticky Ovf flag.
module iiitb_pudc #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             En,
  input  logic             UpOrDown,
  input  logic             Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic [WIDTH-1:0] Limit,
  input  logic             ClrOvf,
  output logic [WIDTH-1:0] Count,
  output logic             Tc,
  output logic             Wrap,
  output logic             Ovf
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             bound_evt;

  // Next-state: Load beats En; a count above a lowered Limit snaps to Limit.
  always_comb begin
    count_d   = count_q;
    wrap_d    = 1'b0;
    bound_evt = 1'b0;
    if (Load) begin
      count_d = (LoadVal <= Limit) ? LoadVal : Limit;
    end else if (En) begin
      if (count_q > Limit) begin
        count_d = Limit;
      end else if (UpOrDown) begin
        if (count_q == Limit) begin
          bound_evt = 1'b1;
          if (!Mode) begin
            count_d = ZERO;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == ZERO) begin
          bound_evt = 1'b1;
          if (!Mode) begin
            count_d = Limit;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
    // A new boundary event wins over a simultaneous clear.
    ovf_d = bound_evt | (ovf_q & ~ClrOvf);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      count_q <= RST_COUNT;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Count = count_q;
  assign Wrap  = wrap_q;
  assign Ovf   = ovf_q;
  assign Tc    = (UpOrDown && (count_q == Limit)) || (!UpOrDown && (count_q == ZERO));

endmodule
